// File: rtl/digit_scan_driver.sv
// Four-digit multiplexed 7-segment scanner: snapshots BCD digits once per frame
// and drives one-hot active-low digit enables with optional leading-zero blanking.
module digit_scan_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] n3,
    input  logic [3:0] n2,
    input  logic [3:0] n1,
    input  logic [3:0] n0,
    input  logic       en,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_slot;
    logic [15:0]   r_shadow;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_snap;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;

    assign w_tick = (r_presc == PRESC_MAX);
    // The snapshot lands on the tick that closes slot 3, so a whole frame shows one value.
    assign w_snap = w_tick && (r_slot == 2'd3);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        w_digit   = r_shadow[3:0];
        w_blank   = 1'b0;
        w_seg_nxt = 7'h00;
        w_an_nxt  = 4'hF;
        case (r_slot)
            2'd0: w_digit = r_shadow[3:0];
            2'd1: begin
                w_digit = r_shadow[7:4];
                w_blank = (r_shadow[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_shadow[11:8];
                w_blank = (r_shadow[15:8] == 8'd0);
            end
            default: begin
                w_digit = r_shadow[15:12];
                w_blank = (r_shadow[15:12] == 4'd0);
            end
        endcase
        if (en && !(blank_lz && w_blank)) begin
            w_seg_nxt = seg_decode(w_digit);
            w_an_nxt  = ~(4'b0001 << r_slot);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc      <= '0;
            r_slot       <= 2'd0;
            r_shadow     <= 16'h0000;
            r_seg        <= 7'h00;
            r_an         <= 4'hF;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_slot <= r_slot + 2'd1;
            end
            if (w_snap) begin
                r_shadow <= {n3, n2, n1, n0};
            end
            r_frame_done <= w_snap;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Self-checking bench for digit_scan_driver: frame-level vector table, hand-written
// timing sequences, and randomized stimulus against a cycle-count based model.
module tb_digit_scan_driver;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] n3 = 4'd0, n2 = 4'd0, n1 = 4'd0, n0 = 4'd0;
    logic       en = 1'b1;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    digit_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .n3         (n3),
        .n2         (n2),
        .n1         (n1),
        .n0         (n0),
        .en         (en),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Reference model: everything derives from the number of clock edges since reset.
    int         m_cyc;
    logic [3:0] m_sh [4];
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic       m_fd;

    typedef struct {
        logic [3:0]       d3, d2, d1, d0;
        logic             blz;
        logic [3:0][6:0]  seg;   // index = slot
        logic [3:0][3:0]  an;
    } vec_t;

    localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   slot;
        int   top;
        logic lit;
        if (!rst) begin
            m_cyc = 0;
            for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
            m_an  = 4'hF;
            m_seg = 7'h00;
            m_fd  = 1'b0;
        end else begin
            slot = (m_cyc / SD) % 4;
            top  = 0;
            for (int k = 0; k < 4; k++) if (m_sh[k] != 4'd0) top = k;
            lit   = en && (!blank_lz || slot <= top);
            m_an  = lit ? ~(4'b0001 << slot) : 4'hF;
            m_seg = lit ? seg_tab[m_sh[slot]] : 7'h00;
            m_fd  = ((m_cyc % FRAME) == FRAME - 1);
            if (m_fd) begin
                m_sh[0] = n0;
                m_sh[1] = n1;
                m_sh[2] = n2;
                m_sh[3] = n3;
            end
            m_cyc++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_an", an, m_an);
        check("model_seg", seg, m_seg);
        check("model_fd", frame_done, m_fd);
    endtask

    // Tick until frame_done is seen (at least one tick); n = ticks taken.
    task automatic wait_fd(output int n, input int limit);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < limit);
        check("fd_seen", frame_done, 1'b1);
    endtask

    function automatic vec_t mk(input logic [3:0] d3, d2, d1, d0, input logic blz,
                                input logic [3:0][6:0] s, input logic [3:0][3:0] a);
        vec_t v;
        v.d3 = d3; v.d2 = d2; v.d1 = d1; v.d0 = d0;
        v.blz = blz; v.seg = s; v.an = a;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;

        vecs[0] = mk(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, AN_ALL);
        vecs[1] = mk(4'd0, 4'd0, 4'd4, 4'd2, 1'b1, {7'h00, 7'h00, 7'h66, 7'h5B},
                     {4'hF, 4'hF, 4'b1101, 4'b1110});
        vecs[2] = mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F},
                     {4'hF, 4'hF, 4'hF, 4'b1110});
        vecs[3] = mk(4'd0, 4'hC, 4'd0, 4'd0, 1'b1, {7'h00, 7'h40, 7'h3F, 7'h3F},
                     {4'hF, 4'b1011, 4'b1101, 4'b1110});
        vecs[4] = mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, AN_ALL);
        vecs[5] = mk(4'd9, 4'd8, 4'd7, 4'd6, 1'b1, {7'h6F, 7'h7F, 7'h07, 7'h7D}, AN_ALL);
        vecs[6] = mk(4'd5, 4'd0, 4'd0, 4'd0, 1'b1, {7'h6D, 7'h3F, 7'h3F, 7'h3F}, AN_ALL);
        vecs[7] = mk(4'hF, 4'hA, 4'd0, 4'd1, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h06}, AN_ALL);
        vecs[8] = mk(4'd0, 4'd0, 4'd1, 4'd0, 1'b1, {7'h00, 7'h00, 7'h06, 7'h3F},
                     {4'hF, 4'hF, 4'b1101, 4'b1110});

        // Reset state, first cycle after release, first snapshot timing.
        rst = 1'b0;
        tick();
        tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h00);
        check("rst_fd", frame_done, 1'b0);
        rst = 1'b1;
        tick();
        check("release_an", an, 4'b1110);
        check("release_seg", seg, 7'h3F);
        wait_fd(n, 4 * FRAME);
        check("first_fd_latency", n, FRAME - 1);

        // Mid-frame input change stays hidden until the next snapshot.
        {n3, n2, n1, n0} = {4'd1, 4'd2, 4'd3, 4'd4};
        wait_fd(n, 4 * FRAME);
        repeat (SD + 1) tick();
        n0 = 4'd9;
        repeat (SD) tick();
        check("hold_slot2_seg", seg, 7'h5B);
        wait_fd(n, 4 * FRAME);
        tick();
        check("new_snap_an", an, 4'b1110);
        check("new_snap_seg", seg, 7'h6F);

        // Display disable keeps the scan timing running.
        wait_fd(n, 4 * FRAME);
        k = 0;
        repeat (3) tick();
        en = 1'b0;
        tick();
        check("dis_an", an, 4'hF);
        check("dis_seg", seg, 7'h00);
        repeat (9) tick();
        k = 13;
        en = 1'b1;
        tick();
        k++;
        check("reen_an", an, 4'b0111);
        check("reen_seg", seg, 7'h06);
        wait_fd(n, 4 * FRAME);
        check("dis_fd_period", k + n, FRAME);

        // One-cycle reset in the middle of slot 2 restarts frame timing.
        wait_fd(n, 4 * FRAME);
        repeat (2 * SD + 2) tick();
        rst = 1'b0;
        tick();
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h00);
        rst = 1'b1;
        tick();
        check("postrst_an", an, 4'b1110);
        check("postrst_seg", seg, 7'h3F);
        wait_fd(n, 4 * FRAME);
        check("postrst_fd_latency", n, FRAME - 1);

        // Frame-level vector table.
        for (int i = 0; i < 9; i++) begin
            {n3, n2, n1, n0} = {vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0};
            blank_lz = vecs[i].blz;
            en = 1'b1;
            wait_fd(n, 4 * FRAME);
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < SD; c++) begin
                    tick();
                    check($sformatf("vec%0d_slot%0d_an", i, s), an, vecs[i].an[s]);
                    check($sformatf("vec%0d_slot%0d_seg", i, s), seg, vecs[i].seg[s]);
                end
            end
        end

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                n3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                n2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                n1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                n0 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/digit_scan_driver.md
DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-low, and clock clk.
REQ-002 The block SHALL provide parameter SCAN_DIV, default 50000, giving the clk cycles per digit slot; legal range is 2 or more.
REQ-003 Ports SHALL be exactly as follows, clock and reset first:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- n3  input  4  BCD digit 3 (most significant)
- n2  input  4  BCD digit 2
- n1  input  4  BCD digit 1
- n0  input  4  BCD digit 0 (least significant)
- en  input  1  display enable
- blank_lz  input  1  leading-zero blanking enable
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
- an  output  4  digit enables, one-hot active-low, registered (an[k] selects digit k)
- frame_done  output  1  one-cycle pulse when a new digit snapshot is latched

Function
REQ-004 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; the cycle in which it equals SCAN_DIV-1 SHALL be a tick.
REQ-005 Slot index SHALL advance by 1 on each tick and wrap from 3 to 0; it SHALL hold between ticks.
REQ-006 On a tick with slot==3, the block SHALL copy n3..n0 into a shadow register and pulse frame_done high for exactly that one cycle.
REQ-007 Displayed values SHALL come only from the shadow register, so input changes mid-frame never appear until the next snapshot.
REQ-008 seg and an SHALL be registered and SHALL reflect the slot and shadow values of the previous cycle (1-cycle latency).
REQ-009 Segment decode SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); values 10-15 SHALL decode to 40 (dash).
REQ-010 Active slot k SHALL drive an[k]=0 and all other an bits =1.
REQ-011 With blank_lz=1, digit k (k=3,2,1) SHALL be blanked when shadow digits k..3 are all zero: seg=00 and an=1111 for that slot.
REQ-012 Digit 0 SHALL never be blanked, so a value of 0 displays as a single "0".
REQ-013 A non-BCD shadow digit (10-15) SHALL count as nonzero for blanking.
REQ-014 With en=0, outputs SHALL be an=1111 and seg=00; prescaler, slot, snapshot and frame_done SHALL continue to run unchanged.
REQ-015 blank_lz and en SHALL be sampled every cycle and take effect on the next output register update.

Reset
REQ-016 While rst=0 at a clk edge, the block SHALL set prescaler=0, slot=0, shadow=0, seg=00, an=1111 and frame_done=0.
REQ-017 Reset SHALL take priority over all other activity, including a reset asserted mid-frame or mid-tick.
REQ-018 In the first cycle after reset release with en=1, outputs SHALL become an=1110 and seg=3F.
REQ-019 The first snapshot after reset SHALL occur on the tick ending slot 3, which is cycle 4*SCAN_DIV after release.

Verification
REQ-020 With SCAN_DIV=4, en=1, blank_lz=0 and n3..n0=1,2,3,4: after the first frame_done, an SHALL cycle 1110/1101/1011/0111 with seg 66/4F/5B/06, each held 4 cycles.
REQ-021 With SCAN_DIV=4, blank_lz=1 and digits 0,0,4,2: slots 3 and 2 SHALL show an=1111 and seg=00; slot 1 SHALL show 66 and slot 0 SHALL show 5B.
REQ-022 With digits 0,0,0,0 and blank_lz=1: only slot 0 SHALL be lit (an=1110, seg=3F); digits 0,C,0,0 SHALL show a dash (40) in slot 2 and 3F in slot 1.
REQ-023 Changing n0 from 4 to 9 during slot 1 of a frame SHALL leave the display unchanged until the next frame_done; afterwards slot 0 SHALL show 6F.
REQ-024 Setting en=0 for 10 cycles SHALL give an=1111 and seg=00 one cycle later, with frame_done period still exactly 4*SCAN_DIV cycles; re-enabling SHALL resume the correct slot.
REQ-025 Asserting rst=0 for one cycle mid-slot-2 SHALL give an=1111 and seg=00 on the next cycle, then an=1110 and seg=3F, and SHALL restart the 4*SCAN_DIV frame timing.
